// File: rtl/switch_conditioner_pkg.sv
// Shared types and helpers for the slide-switch conditioner.
// The optional IRQ output is enabled with SWITCH_CONDITIONER_IRQ_EN.
package switch_conditioner_pkg;

    typedef enum logic {ST_STABLE, ST_COUNTING} db_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    // Counter width for a debounce window; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/switch_conditioner_bit.sv
// One switch bit: 2-FF synchroniser, debounce FSM, edge pulses and sticky change flag.
// Exposes next-flag value for the IRQ term only when SWITCH_CONDITIONER_IRQ_EN is defined.
module debounce_bit
    import switch_conditioner_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sw_raw,
    input  logic i_chg_clr,
    output logic o_sw_db,
    output logic o_sw_rise,
    output logic o_sw_fall,
    output logic o_chg_flag
`ifdef SWITCH_CONDITIONER_IRQ_EN
    ,
    output logic o_chg_flag_next
`endif
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    db_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_db;
    logic          r_rise;
    logic          r_fall;
    logic          r_flag;

    db_state_t     w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_accept;
    logic          w_flag_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (r_s2 != r_db) begin
                    w_state_nxt = ST_COUNTING;
                    w_cnt_nxt   = '0;
                end
            end
            ST_COUNTING: begin
                // Any bounce back to the accepted level restarts the whole window.
                if (r_s2 == r_db) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A new accepted level beats a simultaneous clear strobe.
    assign w_flag_nxt = w_accept | (r_flag & ~i_chg_clr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1    <= RESET_VAL;
            r_s2    <= RESET_VAL;
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_db    <= RESET_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_flag  <= 1'b0;
        end else begin
            r_s1    <= i_sw_raw;
            r_s2    <= r_s1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_db <= r_s2;
            end
            r_rise  <= w_accept & r_s2;
            r_fall  <= w_accept & ~r_s2;
            r_flag  <= w_flag_nxt;
        end
    end

    assign o_sw_db    = r_db;
    assign o_sw_rise  = r_rise;
    assign o_sw_fall  = r_fall;
    assign o_chg_flag = r_flag;
`ifdef SWITCH_CONDITIONER_IRQ_EN
    assign o_chg_flag_next = w_flag_nxt;
`endif

endmodule

// File: rtl/switch_conditioner.sv
// Conditions WIDTH slide-switch bits for the Nios II input PIO.
// Define SWITCH_CONDITIONER_IRQ_EN to add the masked irq output.
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int               WIDTH           = 2,
    parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic [WIDTH-1:0] chg_flag,
    input  logic [WIDTH-1:0] chg_clr
`ifdef SWITCH_CONDITIONER_IRQ_EN
    ,
    input  logic [WIDTH-1:0] irq_mask,
    output logic             irq
`endif
);

`ifdef SWITCH_CONDITIONER_IRQ_EN
    logic [WIDTH-1:0] w_flag_next;
    logic             r_irq;
`endif

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VAL[g])
        ) u_bit (
            .clk             (clk),
            .reset           (reset),
            .i_sw_raw        (sw_raw[g]),
            .i_chg_clr       (chg_clr[g]),
            .o_sw_db         (sw_db[g]),
            .o_sw_rise       (sw_rise[g]),
            .o_sw_fall       (sw_fall[g]),
            .o_chg_flag      (chg_flag[g])
`ifdef SWITCH_CONDITIONER_IRQ_EN
            ,
            .o_chg_flag_next (w_flag_next[g])
`endif
        );
    end

`ifdef SWITCH_CONDITIONER_IRQ_EN
    // Built from next-flag values so irq rises on the same edge as the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(w_flag_next & irq_mask);
        end
    end

    assign irq = r_irq;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with WIDTH=2, DEBOUNCE_CYCLES=4.
// Also exercises irq when SWITCH_CONDITIONER_IRQ_EN is defined.
module tb_switch_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sw_raw;
    logic [1:0] sw_db;
    logic [1:0] sw_rise;
    logic [1:0] sw_fall;
    logic [1:0] chg_flag;
    logic [1:0] chg_clr;
`ifdef SWITCH_CONDITIONER_IRQ_EN
    logic [1:0] irq_mask;
    logic       irq;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    switch_conditioner #(
        .WIDTH           (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_VAL       (2'b00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .sw_db    (sw_db),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .chg_flag (chg_flag),
        .chg_clr  (chg_clr)
`ifdef SWITCH_CONDITIONER_IRQ_EN
        ,
        .irq_mask (irq_mask),
        .irq      (irq)
`endif
    );

    typedef struct {
        logic       rst;
        logic [1:0] raw;
        logic [1:0] clr;
        logic [1:0] db;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] flag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic rst, input logic [1:0] raw, input logic [1:0] clr,
                       input logic [1:0] db, input logic [1:0] rise, input logic [1:0] fall,
                       input logic [1:0] flag);
        vec_t v;
        v.rst = rst; v.raw = raw; v.clr = clr;
        v.db = db; v.rise = rise; v.fall = fall; v.flag = flag;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] db, input logic [1:0] rise,
                             input logic [1:0] fall, input logic [1:0] flag);
        check({tag, ".sw_db"},    sw_db,    db);
        check({tag, ".sw_rise"},  sw_rise,  rise);
        check({tag, ".sw_fall"},  sw_fall,  fall);
        check({tag, ".chg_flag"}, chg_flag, flag);
    endtask

    initial begin
        reset   = 1'b1;
        sw_raw  = 2'b00;
        chg_clr = 2'b00;
`ifdef SWITCH_CONDITIONER_IRQ_EN
        irq_mask = 2'b01;
`endif

        // Reset with both switches up, then first acceptance 6 edges after release.
        add(3, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add(6, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        add(1, 0, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11);
        add(1, 0, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10);
        // Bit 0 falls.
        add(6, 0, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10);
        add(1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b11);
        add(1, 0, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10);
        // Bit 0 rises cleanly.
        add(6, 0, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10);
        add(1, 0, 2'b11, 2'b00, 2'b11, 2'b01, 2'b00, 2'b11);
        add(1, 0, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10);
        // Bit 0 falls again to set up the bounce case.
        add(6, 0, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10);
        add(1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b11);
        add(1, 0, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10);
        // Bounce 1,1,0,0 then held 1: acceptance 6 edges after the last toggle.
        add(2, 0, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10);
        add(2, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10);
        add(6, 0, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10);
        add(1, 0, 2'b11, 2'b00, 2'b11, 2'b01, 2'b00, 2'b11);
        add(1, 0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);
        // Bit 1 falls with a clear on the same edge: set wins; later clears.
        add(6, 0, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);
        add(1, 0, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b11);
        add(1, 0, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01);
        add(1, 0, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01);

        foreach (vecs[i]) begin
            reset   = vecs[i].rst;
            sw_raw  = vecs[i].raw;
            chg_clr = vecs[i].clr;
            step();
            check_all($sformatf("row%0d", i), vecs[i].db, vecs[i].rise, vecs[i].fall, vecs[i].flag);
        end

        // Reset in the middle of a count abandons it.
        reset = 1'b1; sw_raw = 2'b00; chg_clr = 2'b00;
        step();
        reset = 1'b0;
        repeat (3) step();
        sw_raw = 2'b01;
        repeat (5) step();
        check("midcnt.pre_db", sw_db, 2'b00);
        reset = 1'b1;
        step();
        check_all("midcnt.reset", 2'b00, 2'b00, 2'b00, 2'b00);
        reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("midcnt.e%0d.sw_db", i), sw_db, 2'b00);
            check($sformatf("midcnt.e%0d.sw_rise", i), sw_rise, 2'b00);
        end
        step();
        check_all("midcnt.e7", 2'b01, 2'b01, 2'b00, 2'b01);

`ifdef SWITCH_CONDITIONER_IRQ_EN
        check("irq.after_bit0_set", {1'b0, irq}, 2'b01);
        chg_clr = 2'b11;
        step();
        check("irq.cleared", {1'b0, irq}, 2'b00);
        chg_clr = 2'b00;
        sw_raw  = 2'b11;
        for (int i = 1; i <= 7; i++) begin
            step();
            check($sformatf("irq.masked_e%0d", i), {1'b0, irq}, 2'b00);
        end
        check("irq.masked_flag", chg_flag, 2'b10);
        sw_raw = 2'b10;
        repeat (6) step();
        check("irq.bit0_e6", {1'b0, irq}, 2'b00);
        step();
        check("irq.bit0_e7", {1'b0, irq}, 2'b01);
        check("irq.bit0_flag", chg_flag, 2'b11);
        chg_clr = 2'b01;
        step();
        chg_clr = 2'b00;
        check("irq.after_clr", {1'b0, irq}, 2'b00);
        check("irq.after_clr_flag", chg_flag, 2'b10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
